// File: rtl/hsid_sq_df.sv
// Two-stage pipelined squared-difference unit: data_out = (v1 - v2)^2, unsigned.
// Stage 1 registers |v1 - v2|; stage 2 registers its square.

`ifndef HSID_DATA_WIDTH
`define HSID_DATA_WIDTH 16
`endif

module hsid_sq_df #(
  parameter int unsigned DATA_WIDTH = `HSID_DATA_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_WIDTH-1:0]   data_in_v1,
  input  logic [DATA_WIDTH-1:0]   data_in_v2,
  output logic [2*DATA_WIDTH-1:0] data_out
);

  logic [DATA_WIDTH-1:0]   diff_d, diff_q;
  logic [2*DATA_WIDTH-1:0] diff_ext;
  logic [2*DATA_WIDTH-1:0] sq_d, sq_q;

  // max - min keeps the difference exact in DATA_WIDTH bits without a sign bit
  always_comb begin
    diff_d = '0;
    if (data_in_v1 >= data_in_v2) begin
      diff_d = data_in_v1 - data_in_v2;
    end else begin
      diff_d = data_in_v2 - data_in_v1;
    end
  end

  always_comb begin
    diff_ext = {{DATA_WIDTH{1'b0}}, diff_q};
    sq_d     = diff_ext * diff_ext;
  end

  // rst_n keeps its legacy name but is active-high
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      diff_q <= '0;
      sq_q   <= '0;
    end else begin
      diff_q <= diff_d;
      sq_q   <= sq_d;
    end
  end

  assign data_out = sq_q;

endmodule

// File: tb/tb_hsid_sq_df.sv
// Scoreboard bench for hsid_sq_df: driver pushes hand-computed results, monitor pops and compares.

module tb_hsid_sq_df;

  localparam int unsigned DW = 16;

  logic            clk;
  logic            rst_n;
  logic [DW-1:0]   v1;
  logic [DW-1:0]   v2;
  logic [2*DW-1:0] data_out;

  int checks   = 0;
  int failures = 0;

  logic [2*DW-1:0] exp_q[$];
  logic            stg1, stg2;

  hsid_sq_df #(
    .DATA_WIDTH(DW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .data_in_v1(v1),
    .data_in_v2(v2),
    .data_out  (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bench-side latency model: the driver presents a pair on every cycle out of reset
  always @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      stg1 <= 1'b0;
      stg2 <= 1'b0;
    end else begin
      stg1 <= 1'b1;
      stg2 <= stg1;
    end
  end

  // Monitor
  always @(negedge clk) begin
    logic [2*DW-1:0] exp;
    if (stg2) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL pop_empty: data_out=%0h with no expected result queued", data_out);
      end else begin
        exp = exp_q.pop_front();
        if (data_out !== exp) begin
          failures++;
          $display("FAIL stream: data_out=%0h expected=%0h at %0t", data_out, exp, $time);
        end
      end
    end else begin
      checks++;
      if (data_out !== '0) begin
        failures++;
        $display("FAIL idle_zero: data_out=%0h expected=0 at %0t", data_out, $time);
      end
    end
  end

  task automatic drive_now(input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input logic [2*DW-1:0] exp);
    v1 = a;
    v2 = b;
    exp_q.push_back(exp);
  endtask

  task automatic drive(input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [2*DW-1:0] exp);
    @(posedge clk);
    #2;
    drive_now(a, b, exp);
  endtask

  task automatic check_now(input string name, input logic [2*DW-1:0] exp);
    checks++;
    if (data_out !== exp) begin
      failures++;
      $display("FAIL %s: data_out=%0h expected=%0h at %0t", name, data_out, exp, $time);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    v1    = 16'hFFFF;
    v2    = 16'h1234;
    #1 rst_n = 1'b1;
    #1 check_now("async_reset", 32'h0);
    repeat (3) @(posedge clk);
    #1 check_now("reset_held", 32'h0);

    // Release and hold (5,3)
    #1 rst_n = 1'b0;
    drive_now(16'd5, 16'd3, 32'd4);
    repeat (3) drive(16'd5, 16'd3, 32'd4);

    // Order independence and zero
    drive(16'd3, 16'd5, 32'd4);
    drive(16'd77, 16'd77, 32'd0);

    // Extremes
    drive(16'hFFFF, 16'h0000, 32'hFFFE0001);
    drive(16'h0000, 16'hFFFF, 32'hFFFE0001);

    // Back-to-back stream
    drive(16'd10, 16'd4, 32'd36);
    drive(16'd1, 16'd9, 32'd64);
    drive(16'd200, 16'd100, 32'd10000);
    drive(16'd7, 16'd7, 32'd0);

    // Same stream, interrupted by reset with pairs in flight
    drive(16'd10, 16'd4, 32'd36);
    drive(16'd1, 16'd9, 32'd64);
    drive(16'd200, 16'd100, 32'd10000);
    #1 rst_n = 1'b1;
    #1 check_now("midstream_reset", 32'h0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 check_now("midstream_held", 32'h0);

    #1 rst_n = 1'b0;
    drive_now(16'd6, 16'd2, 32'd16);
    drive(16'd6, 16'd2, 32'd16);
    drive(16'd1234, 16'd1000, 32'd54756);
    drive(16'd0, 16'd300, 32'd90000);
    drive(16'd9, 16'd9, 32'd0);

    // Drain the last pair, then park in reset
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    #1 check_now("final_reset", 32'h0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
